// File: rtl/dm_responder_pp.sv
// Data-memory responder for the pipeline MEM stage.
// Accepts single-beat writes and 1..8-beat incrementing read bursts over a
// valid/ready request channel and returns beats on a valid/ready response
// channel after a fixed number of wait states.
module dm_responder_pp #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_last
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [2:0]        len;
    logic [2:0]        beat;
    logic              is_write;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wait_cnt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake outputs, response data and memory write strobe.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_last  = 1'b0;
        rsp_rdata = '0;
        mem_we    = 1'b0;
        mem_waddr = cur_addr;
        mem_wdata = wdata;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        // No wait states: the write commits on the accept edge itself.
                        state_nxt = RESP;
                        mem_we    = rst_n && req_write;
                        mem_waddr = req_addr;
                        mem_wdata = req_wdata;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd1) begin
                    state_nxt = RESP;
                    mem_we    = rst_n && is_write;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_last  = (beat == len);
                rsp_rdata = is_write ? wdata : mem[cur_addr];
                if (rsp_ready && (beat == len)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction context: latch on accept, count wait states, advance beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr <= '0;
            len      <= '0;
            beat     <= '0;
            is_write <= 1'b0;
            wdata    <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur_addr <= req_addr;
                        len      <= req_write ? 3'd0 : req_len;
                        is_write <= req_write;
                        wdata    <= req_wdata;
                        beat     <= '0;
                        wait_cnt <= 4'(WAIT_STATES);
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
                RESP: begin
                    if (rsp_ready && (beat != len)) begin
                        cur_addr <= ADDR_W'(cur_addr + 1'b1);
                        beat     <= beat + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory array; not reset, so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_dm_responder_pp.sv
// Self-checking bench for dm_responder_pp: one instance with two wait states,
// one with none, steered by sel; a plain array models the memory contents.
module tb_dm_responder_pp;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [2:0]  req_len;
    logic        rsp_ready;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_last;
    logic [15:0] a_rsp_rdata;
    logic        z_req_valid, z_req_ready, z_rsp_valid, z_rsp_ready, z_rsp_last;
    logic [15:0] z_rsp_rdata;

    logic        req_ready, rsp_valid, rsp_last;
    logic [15:0] rsp_rdata;

    logic [15:0] ref_a [256];
    logic [15:0] ref_z [256];

    int checks = 0;
    int errors = 0;

    assign a_req_valid = req_valid & ~sel;
    assign a_rsp_ready = rsp_ready & ~sel;
    assign z_req_valid = req_valid & sel;
    assign z_rsp_ready = rsp_ready & sel;
    assign req_ready   = sel ? z_req_ready : a_req_ready;
    assign rsp_valid   = sel ? z_rsp_valid : a_rsp_valid;
    assign rsp_last    = sel ? z_rsp_last  : a_rsp_last;
    assign rsp_rdata   = sel ? z_rsp_rdata : a_rsp_rdata;

    dm_responder_pp #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_last(a_rsp_last)
    );

    dm_responder_pp #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_last(z_rsp_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full transaction on the selected instance, starting and ending at a
    // negedge with the responder idle. stall0 >= 0 fixes the stall count of
    // the first beat; other beats stall 0..3 cycles when rnd_bp is set.
    task automatic xact(input logic wr, input logic [7:0] addr, input logic [15:0] wd,
                        input logic [2:0] ln, input int stall0, input logic rnd_bp);
        int ws, lat, nb, k;
        logic [15:0] expd;
        logic [7:0]  a;
        logic        lst;
        ws = sel ? 0 : 2;
        nb = wr ? 1 : int'(ln) + 1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got %b exp 1", req_ready);
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_len = ln;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != ws + 1) begin
            errors++;
            $display("FAIL latency: got %0d cycles exp %0d", lat, ws + 1);
        end
        if (wr) begin
            if (sel) ref_z[addr] = wd; else ref_a[addr] = wd;
        end
        for (int b = 0; b < nb; b++) begin
            a    = addr + 8'(b);
            expd = wr ? wd : (sel ? ref_z[a] : ref_a[a]);
            lst  = (b == nb - 1);
            k    = (b == 0 && stall0 >= 0) ? stall0 : (rnd_bp ? int'($urandom_range(0, 3)) : 0);
            for (int s = 0; s <= k; s++) begin
                rsp_ready = (s == k);
                checks++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== expd || rsp_last !== lst || req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL beat%0d addr %h: got v=%b d=%h l=%b rr=%b exp v=1 d=%h l=%b rr=0",
                             b, a, rsp_valid, rsp_rdata, rsp_last, req_ready, expd, lst);
                end
                @(negedge clk);
            end
            rsp_ready = 1'b0;
        end
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL end_idle: got v=%b rr=%b exp v=0 rr=1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            sel = (i == 1);
            #1;
            checks++;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_last !== 1'b0 || rsp_rdata !== 16'h0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got rr=%b v=%b l=%b d=%h exp 1 0 0 0000",
                         i, req_ready, rsp_valid, rsp_last, rsp_rdata);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_write_latency();
        sel = 1'b0;
        xact(1'b1, 8'h12, 16'hBEEF, 3'd0, 0, 1'b0);
        xact(1'b0, 8'h12, 16'h0, 3'd0, 0, 1'b0);
    endtask

    task automatic test_preload();
        sel = 1'b0;
        for (int i = 0; i < 256; i++) begin
            xact(1'b1, 8'(i), 16'($urandom), 3'($urandom), -1, 1'b1);
        end
    endtask

    task automatic test_wrap();
        sel = 1'b0;
        xact(1'b1, 8'hFE, 16'hA0A0, 3'd0, 0, 1'b0);
        xact(1'b1, 8'hFF, 16'hB1B1, 3'd0, 0, 1'b0);
        xact(1'b1, 8'h00, 16'hC2C2, 3'd0, 0, 1'b0);
        xact(1'b1, 8'h01, 16'hD3D3, 3'd0, 0, 1'b0);
        xact(1'b0, 8'hFE, 16'h0, 3'd3, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        xact(1'b0, 8'($urandom), 16'h0, 3'd1, 5, 1'b0);
    endtask

    task automatic test_random();
        sel = 1'b0;
        for (int i = 0; i < 50; i++) begin
            xact(1'($urandom), 8'($urandom), 16'($urandom), 3'($urandom), -1, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ra, wa;
        logic [15:0] wd;
        int cyc, last_cyc, acc_cyc, bi, t;
        sel = 1'b0;
        ra = 8'($urandom); wa = 8'($urandom); wd = 16'($urandom);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = ra; req_len = 3'd1;
        @(negedge clk);
        req_write = 1'b1; req_addr = wa; req_wdata = wd;
        cyc = 1; last_cyc = -1; acc_cyc = -1; bi = 0;
        while (cyc < 40 && acc_cyc < 0) begin
            checks++;
            if (req_ready === 1'b1 && rsp_valid === 1'b1) begin
                errors++;
                $display("FAIL exclusive: got rr=1 v=1 exp not both");
            end
            if (req_ready === 1'b1) begin
                acc_cyc = cyc;
            end else if (rsp_valid === 1'b1) begin
                checks++;
                if (rsp_rdata !== ref_a[ra + 8'(bi)] || rsp_last !== (bi == 1)) begin
                    errors++;
                    $display("FAIL b2b_beat%0d: got d=%h l=%b exp d=%h l=%b",
                             bi, rsp_rdata, rsp_last, ref_a[ra + 8'(bi)], (bi == 1));
                end
                if (rsp_last === 1'b1) last_cyc = cyc;
                bi++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (last_cyc != 4 || acc_cyc != 5) begin
            errors++;
            $display("FAIL b2b_accept: got last=%0d accept=%0d exp last=4 accept=5", last_cyc, acc_cyc);
        end
        req_valid = 1'b0;
        ref_a[wa] = wd;
        t = 0;
        while (rsp_valid !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== wd || rsp_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_write_rsp: got v=%b d=%h l=%b exp v=1 d=%h l=1", rsp_valid, rsp_rdata, rsp_last, wd);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        xact(1'b0, wa, 16'h0, 3'd0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [7:0]  wa, ra, va;
        logic [15:0] wd;
        int t;
        sel = 1'b0;
        wa = 8'h33; wd = 16'($urandom); ra = 8'h80; va = 8'h55;
        xact(1'b1, wa, wd, 3'd0, 0, 1'b0);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = ra; req_len = 3'd7;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (rsp_valid !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== ref_a[ra + 8'd1]) begin
            errors++;
            $display("FAIL mid_beat2: got v=%b d=%h exp v=1 d=%h", rsp_valid, rsp_rdata, ref_a[ra + 8'd1]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b rr=%b l=%b exp v=0 rr=1 l=0", rsp_valid, req_ready, rsp_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_beats: got v=%b exp 0", rsp_valid);
        end
        xact(1'b0, wa, 16'h0, 3'd0, 0, 1'b0);
        // Abort a write while it is still waiting; the old value must remain.
        req_valid = 1'b1; req_write = 1'b1; req_addr = va; req_wdata = ~ref_a[va];
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xact(1'b0, va, 16'h0, 3'd0, 0, 1'b0);
    endtask

    task automatic test_zero_wait();
        sel = 1'b1;
        #1;
        xact(1'b1, 8'h40, 16'($urandom), 3'd0, 0, 1'b0);
        xact(1'b1, 8'h41, 16'($urandom), 3'd0, 0, 1'b0);
        xact(1'b0, 8'h40, 16'h0, 3'd0, 0, 1'b0);
        xact(1'b0, 8'h40, 16'h0, 3'd1, -1, 1'b1);
        sel = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_len = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_write_latency();
        test_preload();
        test_wrap();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_zero_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
